// File: rtl/ctr_record_buffer.sv
// ctr_record_buffer
//   Receiving end of the CTR emitter interface. Filters emitted control-transfer
//   records by privilege, type and freeze state, stores accepted records in a
//   circular buffer of DEPTH entries, and serves CSR reads by logical index
//   (0 = most recent) together with the sctrstatus WRPTR/FROZEN fields.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rec_*_i              emitted record (valid, source PC, target PC, type, privilege)
//   ctl_en_i             recording enable {M,S,U}
//   ctl_type_inh_i       per-type inhibit, bit t drops records of type t
//   clear_i              sctrclr pulse: zero every entry and WRPTR
//   wrptr_we_i/wdata_i   CSR write of WRPTR
//   frozen_we_i/wdata_i  CSR write of FROZEN
//   rd_idx_i             logical read index
//   rd_source_o          {source pc, valid}
//   rd_target_o          {target pc, mispredict = 0}
//   rd_data_o            {zeros, type}
//   wrptr_o, frozen_o    sctrstatus fields
module ctr_record_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rec_valid_i,
  input  logic [XLEN-2:0]  rec_source_i,
  input  logic [XLEN-2:0]  rec_target_i,
  input  logic [3:0]       rec_type_i,
  input  logic [1:0]       rec_priv_i,
  input  logic [2:0]       ctl_en_i,
  input  logic [15:0]      ctl_type_inh_i,
  input  logic             clear_i,
  input  logic             wrptr_we_i,
  input  logic [IDX_W-1:0] wrptr_wdata_i,
  input  logic             frozen_we_i,
  input  logic             frozen_wdata_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [XLEN-1:0]  rd_source_o,
  output logic [XLEN-1:0]  rd_target_o,
  output logic [XLEN-1:0]  rd_data_o,
  output logic [IDX_W-1:0] wrptr_o,
  output logic             frozen_o
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // Input stage
  logic             s1_valid_r;
  logic [XLEN-2:0]  s1_source_r;
  logic [XLEN-2:0]  s1_target_r;
  logic [3:0]       s1_type_r;

  // Buffer storage and status
  logic [XLEN-2:0]  src_mem_r  [DEPTH];
  logic [XLEN-2:0]  tgt_mem_r  [DEPTH];
  logic [3:0]       type_mem_r [DEPTH];
  logic             v_mem_r    [DEPTH];
  logic [IDX_W-1:0] wrptr_r;
  logic             frozen_r;

  logic             priv_ok_s;
  logic             capture_s;
  logic [IDX_W-1:0] rd_phys_s;

  // Privilege filter: privilege 2 is never recorded
  always_comb begin
    priv_ok_s = 1'b0;
    case (rec_priv_i)
      2'd0:    priv_ok_s = ctl_en_i[0];
      2'd1:    priv_ok_s = ctl_en_i[1];
      2'd3:    priv_ok_s = ctl_en_i[2];
      default: priv_ok_s = 1'b0;
    endcase
  end

  assign capture_s = rec_valid_i & ~frozen_r & (rec_type_i != 4'd0) &
                     ~ctl_type_inh_i[rec_type_i] & priv_ok_s;

  // Input stage register; capture stays live on clear/WRPTR-write edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r  <= 1'b0;
      s1_source_r <= '0;
      s1_target_r <= '0;
      s1_type_r   <= 4'd0;
    end else begin
      s1_valid_r <= capture_s;
      if (capture_s) begin
        s1_source_r <= rec_source_i;
        s1_target_r <= rec_target_i;
        s1_type_r   <= rec_type_i;
      end
    end
  end

  // Buffer write and WRPTR: clear beats WRPTR write beats the stage-2 record
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src_mem_r[i]  <= '0;
        tgt_mem_r[i]  <= '0;
        type_mem_r[i] <= 4'd0;
        v_mem_r[i]    <= 1'b0;
      end
    end else if (clear_i) begin
      wrptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src_mem_r[i]  <= '0;
        tgt_mem_r[i]  <= '0;
        type_mem_r[i] <= 4'd0;
        v_mem_r[i]    <= 1'b0;
      end
    end else if (wrptr_we_i) begin
      wrptr_r <= wrptr_wdata_i;
    end else if (s1_valid_r) begin
      src_mem_r[wrptr_r]  <= s1_source_r;
      tgt_mem_r[wrptr_r]  <= s1_target_r;
      type_mem_r[wrptr_r] <= s1_type_r;
      v_mem_r[wrptr_r]    <= 1'b1;
      wrptr_r             <= wrptr_r + IDX_ONE;
    end
  end

  // FROZEN status, written only by the CSR
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frozen_r <= 1'b0;
    end else if (frozen_we_i) begin
      frozen_r <= frozen_wdata_i;
    end
  end

  // Logical index 0 is the entry just behind the write pointer; wraps mod DEPTH
  assign rd_phys_s   = wrptr_r - IDX_ONE - rd_idx_i;
  assign rd_source_o = {src_mem_r[rd_phys_s], v_mem_r[rd_phys_s]};
  assign rd_target_o = {tgt_mem_r[rd_phys_s], 1'b0};
  assign rd_data_o   = {{(XLEN-4){1'b0}}, type_mem_r[rd_phys_s]};
  assign wrptr_o     = wrptr_r;
  assign frozen_o    = frozen_r;

endmodule

// File: tb/tb_ctr_record_buffer.sv
// tb_ctr_record_buffer
//   Directed bench for ctr_record_buffer (XLEN=64, DEPTH=16). Inputs change on
//   the falling edge; outputs are sampled on the falling edge or shortly after.
module tb_ctr_record_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic             clk_i;
  logic             rst_ni;
  logic             rec_valid_i;
  logic [XLEN-2:0]  rec_source_i;
  logic [XLEN-2:0]  rec_target_i;
  logic [3:0]       rec_type_i;
  logic [1:0]       rec_priv_i;
  logic [2:0]       ctl_en_i;
  logic [15:0]      ctl_type_inh_i;
  logic             clear_i;
  logic             wrptr_we_i;
  logic [IDX_W-1:0] wrptr_wdata_i;
  logic             frozen_we_i;
  logic             frozen_wdata_i;
  logic [IDX_W-1:0] rd_idx_i;
  logic [XLEN-1:0]  rd_source_o;
  logic [XLEN-1:0]  rd_target_o;
  logic [XLEN-1:0]  rd_data_o;
  logic [IDX_W-1:0] wrptr_o;
  logic             frozen_o;

  int n_checks = 0;
  int n_pass   = 0;

  ctr_record_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rec_valid_i    (rec_valid_i),
    .rec_source_i   (rec_source_i),
    .rec_target_i   (rec_target_i),
    .rec_type_i     (rec_type_i),
    .rec_priv_i     (rec_priv_i),
    .ctl_en_i       (ctl_en_i),
    .ctl_type_inh_i (ctl_type_inh_i),
    .clear_i        (clear_i),
    .wrptr_we_i     (wrptr_we_i),
    .wrptr_wdata_i  (wrptr_wdata_i),
    .frozen_we_i    (frozen_we_i),
    .frozen_wdata_i (frozen_wdata_i),
    .rd_idx_i       (rd_idx_i),
    .rd_source_o    (rd_source_o),
    .rd_target_o    (rd_target_o),
    .rd_data_o      (rd_data_o),
    .wrptr_o        (wrptr_o),
    .frozen_o       (frozen_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected rd_source for a stored record: {pc, v=1}
  function automatic logic [63:0] src_word(input logic [62:0] pc);
    return {pc, 1'b1};
  endfunction

  function automatic logic [63:0] tgt_word(input logic [62:0] pc);
    return {pc, 1'b0};
  endfunction

  // Present one record for one rising edge; returns on the following falling edge
  task automatic send_rec(input logic [62:0] src, input logic [62:0] tgt,
                          input logic [3:0] typ, input logic [1:0] priv);
    rec_valid_i  = 1'b1;
    rec_source_i = src;
    rec_target_i = tgt;
    rec_type_i   = typ;
    rec_priv_i   = priv;
    @(negedge clk_i);
    rec_valid_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic set_idx(input logic [IDX_W-1:0] i);
    rd_idx_i = i;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    rec_valid_i = 1'b0; rec_source_i = '0; rec_target_i = '0;
    rec_type_i = 4'd0; rec_priv_i = 2'd0;
    ctl_en_i = 3'b000; ctl_type_inh_i = 16'h0000;
    clear_i = 1'b0; wrptr_we_i = 1'b0; wrptr_wdata_i = 4'd0;
    frozen_we_i = 1'b0; frozen_wdata_i = 1'b0; rd_idx_i = 4'd0;
    idle(2);
    rst_ni = 1'b1;
    #1;

    // Reset state
    check("rst_wrptr", 64'(wrptr_o), 64'd0);
    check("rst_frozen", 64'(frozen_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      set_idx(4'(i));
      check($sformatf("rst_rd%0d", i), rd_source_o | rd_target_o | rd_data_o, 64'd0);
    end
    idle(1);

    // Three M-privilege records
    ctl_en_i = 3'b100;
    send_rec(63'h100, 63'h108, 4'd1, 2'd3);
    send_rec(63'h200, 63'h208, 4'd1, 2'd3);
    send_rec(63'h300, 63'h308, 4'd1, 2'd3);
    idle(1);
    check("three_wrptr", 64'(wrptr_o), 64'd3);
    set_idx(4'd0);
    check("three_src0", rd_source_o, src_word(63'h300));
    check("three_tgt0", rd_target_o, tgt_word(63'h308));
    check("three_data0", rd_data_o, 64'd1);
    set_idx(4'd1);
    check("three_src1", rd_source_o, src_word(63'h200));
    set_idx(4'd2);
    check("three_src2", rd_source_o, src_word(63'h100));
    set_idx(4'd3);
    check("three_src3", rd_source_o, 64'd0);
    idle(1);

    // Idle clear, then DEPTH+2 back-to-back records wrap the buffer
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    check("clr_wrptr", 64'(wrptr_o), 64'd0);
    set_idx(4'd0);
    check("clr_src0", rd_source_o, 64'd0);
    idle(1);
    for (int n = 1; n <= DEPTH + 2; n++) begin
      send_rec(63'(n * 4), 63'(n * 4 + 2), 4'd2, 2'd3);
    end
    idle(1);
    check("wrap_wrptr", 64'(wrptr_o), 64'd2);
    set_idx(4'd0);
    check("wrap_src0", rd_source_o, src_word(63'd72));
    check("wrap_tgt0", rd_target_o, tgt_word(63'd74));
    check("wrap_data0", rd_data_o, 64'd2);
    set_idx(4'd1);
    check("wrap_src1", rd_source_o, src_word(63'd68));
    set_idx(4'd15);
    check("wrap_src15", rd_source_o, src_word(63'd12));
    idle(1);

    // Filtered records: U disabled, inhibited type 5, type 0, privilege 2
    ctl_en_i = 3'b110;
    send_rec(63'h400, 63'h404, 4'd1, 2'd0);
    ctl_en_i = 3'b111;
    ctl_type_inh_i = 16'h0020;
    send_rec(63'h500, 63'h504, 4'd5, 2'd3);
    ctl_type_inh_i = 16'h0000;
    send_rec(63'h600, 63'h604, 4'd0, 2'd3);
    send_rec(63'h700, 63'h704, 4'd1, 2'd2);
    idle(1);
    check("filt_wrptr", 64'(wrptr_o), 64'd2);
    set_idx(4'd0);
    check("filt_src0", rd_source_o, src_word(63'd72));
    idle(1);

    // Freeze blocks capture
    frozen_we_i = 1'b1; frozen_wdata_i = 1'b1;
    idle(1);
    frozen_we_i = 1'b0;
    check("frz_set", 64'(frozen_o), 64'd1);
    for (int n = 0; n < 4; n++) send_rec(63'(12'h800 + n), 63'h0, 4'd1, 2'd3);
    idle(1);
    check("frz_wrptr", 64'(wrptr_o), 64'd2);
    set_idx(4'd0);
    check("frz_src0", rd_source_o, src_word(63'd72));
    idle(1);
    frozen_we_i = 1'b1; frozen_wdata_i = 1'b0;
    idle(1);
    frozen_we_i = 1'b0;
    check("frz_clr", 64'(frozen_o), 64'd0);
    send_rec(63'h55, 63'h56, 4'd3, 2'd1);
    check("lat_wrptr_before", 64'(wrptr_o), 64'd2);
    idle(1);
    check("unfrz_wrptr", 64'(wrptr_o), 64'd3);
    set_idx(4'd0);
    check("unfrz_src0", rd_source_o, src_word(63'h55));
    check("unfrz_data0", rd_data_o, 64'd3);
    idle(1);

    // FROZEN set on the capture edge: record already in stage 2 is still written
    frozen_we_i = 1'b1; frozen_wdata_i = 1'b1;
    send_rec(63'h66, 63'h67, 4'd4, 2'd3);
    frozen_we_i = 1'b0;
    idle(1);
    check("frz2_wrptr", 64'(wrptr_o), 64'd4);
    check("frz2_frozen", 64'(frozen_o), 64'd1);
    set_idx(4'd0);
    check("frz2_src0", rd_source_o, src_word(63'h66));
    idle(1);
    frozen_we_i = 1'b1; frozen_wdata_i = 1'b0;
    idle(1);
    frozen_we_i = 1'b0;

    // Clear while stage 2 holds a record: record dropped, buffer zeroed
    send_rec(63'h77, 63'h78, 4'd1, 2'd3);
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    check("clr2_wrptr", 64'(wrptr_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      set_idx(4'(i));
      check($sformatf("clr2_rd%0d", i), rd_source_o | rd_data_o, 64'd0);
    end
    idle(1);
    check("clr2_wrptr_after", 64'(wrptr_o), 64'd0);

    // WRPTR write on the stage-2 write edge: pointer loaded, record dropped
    send_rec(63'h88, 63'h89, 4'd1, 2'd3);
    wrptr_we_i = 1'b1; wrptr_wdata_i = 4'd5;
    idle(1);
    wrptr_we_i = 1'b0;
    check("wp_wrptr", 64'(wrptr_o), 64'd5);
    set_idx(4'd0);
    check("wp_src0", rd_source_o, 64'd0);
    set_idx(4'd4);
    check("wp_src4", rd_source_o, 64'd0);
    idle(1);
    check("wp_wrptr_hold", 64'(wrptr_o), 64'd5);
    send_rec(63'h99, 63'h9a, 4'd6, 2'd0);
    idle(1);
    check("wp_next_wrptr", 64'(wrptr_o), 64'd6);
    set_idx(4'd0);
    check("wp_next_src0", rd_source_o, src_word(63'h99));

    // Asynchronous reset mid-cycle
    idle(1);
    frozen_we_i = 1'b1; frozen_wdata_i = 1'b1;
    idle(1);
    frozen_we_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_wrptr", 64'(wrptr_o), 64'd0);
    check("arst_frozen", 64'(frozen_o), 64'd0);
    set_idx(4'd15);
    check("arst_src15", rd_source_o, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
